fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the LEGv8 pipelined core. Owns the program counter and drives the word address into the combinational instruction memory (imem).
- Captures the returned instruction together with its PC into the IF/ID pipeline register.
- Supports stall from hazard detection and PC redirect with flush from branch resolution.
- Sits between the branch unit and hazard unit (control in) and the decode stage (IF/ID out).

Parameters:
- N, 64, datapath and PC width in bits.
- IW, 32, instruction width in bits.
- AW, 6, imem word-address width (64-word ROM).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- stall_i  in  1  hold PC and IF/ID contents this cycle.
- redirect_i  in  1  branch taken; load target, squash the instruction in IF.
- target_i  in  N  redirect target byte address.
- imem_addr_o  out  AW  word address to imem, equal to pc[AW+1:2].
- imem_q_i  in  IW  instruction from imem; valid in the same cycle (combinational ROM).
- pc_o  out  N  current fetch PC.
- if_id_pc_o  out  N  PC of the instruction held in IF/ID.
- if_id_instr_o  out  IW  instruction held in IF/ID.
- if_id_valid_o  out  1  IF/ID holds a real instruction (0 = bubble).
- fetch_count_o  out  32  number of instructions accepted into IF/ID since reset.

Behaviour:
- Reset (reset==0 at a rising edge):
  - pc = RESET_PC.
  - if_id_pc = 0, if_id_instr = 0, if_id_valid = 0.
  - fetch_count = 0.
  - Reset overrides all other inputs, including mid-stall or mid-redirect.
- imem_addr_o = pc[AW+1:2], combinational. pc[1:0] is ignored.
- Address wrap-around: PC values of 256 and above alias into the 64-word ROM, e.g. pc=0x100 reads word 0. No error is flagged.
- Per-cycle update, evaluated in priority order when reset==1:
  1. redirect_i=1: pc <= {target_i[N-1:2],2'b00}; IF/ID <= bubble (valid=0, instr=0, pc=0); fetch_count unchanged. Redirect wins over a simultaneous stall_i.
  2. stall_i=1: pc, IF/ID and fetch_count all hold their values.
  3. Otherwise: IF/ID <= {pc, imem_q_i, valid=1}; pc <= pc+4; fetch_count <= fetch_count+1.
- PC arithmetic is modulo 2^N. fetch_count wraps modulo 2^32.
- Timing:
  - Latency from pc to IF/ID is 1 cycle.
  - The first valid instruction appears on the first rising edge after reset is released.
  - After a redirect, the target instruction is valid in IF/ID 2 edges after redirect_i was sampled: the redirect edge produces a bubble, the following edge captures the target.
- Target alignment: target_i[1:0] != 0 is silently truncated to word alignment.
- State is implicit (no FSM): pc, the IF/ID register and the counter, plus the 3-way priority mux.
- All registers update on the rising edge of clk only. There is no combinational path from imem_q_i to any output except through IF/ID.

Decomposition:
- Shared package (core_pkg):
  - Widths N, IW, AW.
  - RESET_PC.
  - NOP/bubble encoding (32'h0).
  - Struct typedef if_id_t {pc, instr, valid}, reused by the decode stage.
- One sub-module, if_id_reg: the IF/ID pipeline register with enable (= ~stall) and synchronous clear (= redirect). It is reused for the ID/EX and EX/MEM registers.
- The PC register and next-PC mux stay in fetch_stage.

Test Plan:
- Reset then free-run, with imem word0=32'hf8000001 and word1=32'hf8008002:
  - Edge 1: IF/ID = {pc 0, 32'hf8000001, valid 1}.
  - Edge 2: IF/ID = {pc 4, 32'hf8008002}; pc_o=8; fetch_count=2.
- stall_i high for 3 cycles at pc=0x10: pc_o stays 0x10, IF/ID is unchanged, fetch_count is unchanged. Release: the next edge captures the word at index 4.
- redirect_i=1 with target_i=0x24 at pc=0x0C:
  - Next edge: valid=0, pc_o=0x24.
  - Following edge: IF/ID.pc=0x24, instr=word 9.
- redirect_i and stall_i both high with target 0x40: redirect wins; pc_o=0x40 and IF/ID is a bubble.
- reset driven low mid-stream at pc=0x80 with stall high: next edge gives pc_o=0, valid=0, fetch_count=0.
- Wrap and alignment: target_i=0x103 gives pc_o=0x100, imem_addr_o=0, and the fetched instruction is word 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared LEGv8 core definitions: datapath widths, reset PC, bubble encoding
// and the IF/ID payload reused by the decode stage.
package core_pkg;

  localparam int unsigned N  = 64;
  localparam int unsigned IW = 32;
  localparam int unsigned AW = 6;

  localparam logic [N-1:0]  RESET_PC  = '0;
  localparam logic [IW-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [N-1:0]  pc;
    logic [IW-1:0] instr;
    logic          valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the
// combinational imem ROM (slave).
interface fetch_stage_if #(
  parameter int unsigned AW = core_pkg::AW,
  parameter int unsigned IW = core_pkg::IW
);

  logic [AW-1:0] imem_addr_o;
  logic [IW-1:0] imem_q_i;

  modport master (output imem_addr_o, input  imem_q_i);
  modport slave  (input  imem_addr_o, output imem_q_i);

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register with enable and synchronous clear; the cleared
// value is an all-zero bubble. Reused for IF/ID, ID/EX and EX/MEM.
module if_id_reg
  import core_pkg::*;
#(
  parameter type T = if_id_t
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  T     d,
  output T     q
);

  // Clear beats enable so a flush squashes even a stalled stage.
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, next-PC priority mux
// (reset > redirect > stall > advance), and the IF/ID capture register.
module fetch_stage #(
  parameter int unsigned   N        = core_pkg::N,
  parameter int unsigned   IW       = core_pkg::IW,
  parameter int unsigned   AW       = core_pkg::AW,
  parameter logic [N-1:0]  RESET_PC = N'(core_pkg::RESET_PC)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [N-1:0]        target_i,
  fetch_stage_if.master       bus,
  output logic [N-1:0]        pc_o,
  output logic [N-1:0]        if_id_pc_o,
  output logic [IW-1:0]       if_id_instr_o,
  output logic                if_id_valid_o,
  output logic [31:0]         fetch_count_o
);

  typedef struct packed {
    logic [N-1:0]  pc;
    logic [IW-1:0] instr;
    logic          valid;
  } stage_t;

  logic [N-1:0] pc;
  logic [31:0]  fetch_count;
  stage_t       capture;
  stage_t       if_id;

  // Upper PC bits are ignored, so fetches beyond 64 words alias the ROM.
  assign bus.imem_addr_o = pc[AW+1:2];

  always_comb begin
    capture       = '0;
    capture.pc    = pc;
    capture.instr = bus.imem_q_i;
    capture.valid = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      fetch_count <= '0;
    end else if (redirect_i) begin
      pc          <= target_i & ~N'(3);
    end else if (!stall_i) begin
      pc          <= pc + N'(4);
      fetch_count <= fetch_count + 32'd1;
    end
  end

  if_id_reg #(
    .T (stage_t)
  ) u_if_id (
    .clk   (clk),
    .reset (reset),
    .en    (!stall_i),
    .clr   (redirect_i),
    .d     (capture),
    .q     (if_id)
  );

  assign pc_o          = pc;
  assign if_id_pc_o    = if_id.pc;
  assign if_id_instr_o = if_id.instr;
  assign if_id_valid_o = if_id.valid;
  assign fetch_count_o = fetch_count;

endmodule
